// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute-stage multiply/divide unit.
// Contents: operation encoding, FSM state encoding and the iteration count.
package mips_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    localparam int unsigned MULDIV_ITERS = 32;

endpackage

// File: rtl/mips_muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   is_div   - 1: restoring-divide step, 0: shift-add multiply step
//   acc      - {upper, lower} working register (product or {remainder, quotient})
//   operand  - multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_next - working register after this iteration
module mips_muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   part;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        // Upper half after a left shift, keeping the bit shifted out of the top.
        part = acc[2*WIDTH-1:WIDTH-1];
        // A successful trial subtract always leaves less than the divisor,
        // so the low WIDTH bits carry the whole difference.
        diff = part[WIDTH-1:0] - operand;
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
        if (is_div) begin
            if (part >= {1'b0, operand}) begin
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative radix-2 multiply/divide unit producing the MIPS HI/LO pair.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   start, op    - request strobe and operation (muldiv_op_t encoding)
//   op_a, op_b   - rs / rt operands
//   busy         - high while a MULT/DIV is in flight
//   done         - one-cycle pulse when HI/LO take a new result
//   hi, lo       - HI/LO registers
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(MULDIV_ITERS);

    muldiv_state_t      state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic               is_div_q, is_div_d;
    logic               res_neg_q, res_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               op_signed, op_is_div, op_is_arith;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;

    assign op_signed   = (op == MULT) || (op == DIV);
    assign op_is_div   = (op == DIV) || (op == DIVU);
    assign op_is_arith = (op == MULT) || (op == MULTU) || op_is_div;
    assign a_neg       = op_signed && op_a[WIDTH-1];
    assign b_neg       = op_signed && op_b[WIDTH-1];
    assign a_mag       = a_neg ? -op_a : op_a;
    assign b_mag       = b_neg ? -op_b : op_b;
    assign prod_fix    = res_neg_q ? -acc_q : acc_q;

    mips_muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .operand  (operand_q),
        .acc_next (step_acc)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        operand_d = operand_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && op_is_arith) begin
                    state_d  = RUN;
                    count_d  = '0;
                    is_div_d = op_is_div;
                    if (op_is_div) begin
                        acc_d     = {{WIDTH{1'b0}}, a_mag};
                        operand_d = b_mag;
                        // Divide by zero keeps an all-ones quotient unnegated.
                        res_neg_d = (a_neg ^ b_neg) && (op_b != '0);
                        rem_neg_d = a_neg;
                    end else begin
                        acc_d     = {{WIDTH{1'b0}}, b_mag};
                        operand_d = a_mag;
                        res_neg_d = a_neg ^ b_neg;
                        rem_neg_d = 1'b0;
                    end
                end else if (start && (op == MTHI)) begin
                    hi_d = op_a;
                end else if (start && (op == MTLO)) begin
                    lo_d = op_a;
                end
            end
            RUN: begin
                acc_d   = step_acc;
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(MULDIV_ITERS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            operand_q <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            operand_q <= operand_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
